// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetch with a small prefetch queue; define IFETCH_DROP_CNT_EN to add the drop_count output
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_DROP_CNT_EN
  ,
  output logic [31:0] drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  // One extra bit beyond what count needs so occupancy (count + inflight) never overflows.
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [63:0]   q_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic          accept;
  logic          enq;
  logic          deq;

  // Issue, enqueue and dequeue decisions; a slot is reserved for every request in flight
  always_comb begin
    inst_valid     = !reset && (count != '0) && !redirect_valid;
    deq            = inst_valid && inst_ready;
    occ            = count + CW'(inflight) - CW'(deq);
    imem_req_valid = !reset && !redirect_valid && (occ < DEPTH_C);
    accept         = imem_req_valid && imem_req_ready;
    enq            = imem_resp_valid && inflight && !kill && !redirect_valid;
  end

  assign imem_req_addr = fetch_pc;
  assign inst_pc       = q_mem[rd_ptr][63:32];
  assign inst_data     = q_mem[rd_ptr][31:0];

  // Fetch pointer, in-flight tracking and queue bookkeeping; redirect flushes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= accept;
      kill     <= redirect_valid && inflight;
      if (accept) inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (enq)    wr_ptr   <= wr_ptr + PW'(1);
        if (deq)    rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Queue storage holds {pc, instruction}; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && enq) q_mem[wr_ptr] <= {inflight_pc, imem_resp_data};
  end

`ifdef IFETCH_DROP_CNT_EN
  // Count responses thrown away by a redirect in the same cycle or by the following kill cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (imem_resp_valid && (kill || (inflight && redirect_valid))) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule
